// File: rtl/host_cmd_bridge_pkg.sv
// Shared constants and state types for the host command bridge.
package host_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] ACK_BYTE   = 8'h5A;
  localparam logic [7:0] NACK_BYTE  = 8'hEE;
  localparam logic [3:0] SAMPLE_TAG = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CW,
    S_CH,
    S_CL,
    S_NH,
    S_NL,
    S_CK
  } parseState_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_ACK,
    T_HI,
    T_LO
  } txState_t;

endpackage

// File: rtl/host_cmd_bridge_if.sv
// Host byte link, controller bus and ADC return path of the bridge.
interface host_cmd_bridge_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  ctrl_word;
  logic [15:0] conf_word;
  logic        mode_adc;
  logic [11:0] n_samples;
  logic        ctrl_en;
  logic [11:0] data_adc;
  logic        ready_adc;
  logic        overflow;
  logic        frame_err;

  // Host/controller side: drives the link inputs, observes the bridge outputs.
  modport master (
    output rx_data, rx_valid, tx_ready, data_adc, ready_adc,
    input  tx_data, tx_valid, ctrl_word, conf_word, mode_adc, n_samples,
           ctrl_en, overflow, frame_err
  );

  // Bridge side.
  modport slave (
    input  rx_data, rx_valid, tx_ready, data_adc, ready_adc,
    output tx_data, tx_valid, ctrl_word, conf_word, mode_adc, n_samples,
           ctrl_en, overflow, frame_err
  );
endinterface

// File: rtl/host_cmd_bridge_sample_fifo.sv
// Synchronous first-word-fall-through FIFO for 12-bit ADC samples.
// A push while full is accepted only if a pop happens in the same cycle.
module sample_fifo #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [11:0] din,
  output logic [11:0] dout,
  output logic        full,
  output logic        empty
);

  logic [11:0] mem [0:(1<<AW)-1];
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;
  logic        wrEn;
  logic        rdEn;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign rdEn  = pop && !empty;
  assign wrEn  = push && (!full || rdEn);
  assign dout  = mem[rdPtr[AW-1:0]];

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr[AW-1:0]] <= din;
  end

  // Read and write pointers with one extra wrap bit to tell full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (rdEn) rdPtr <= rdPtr + 1'b1;
    end
  end

endmodule

// File: rtl/host_cmd_bridge.sv
// Host command bridge: parses 7-byte command frames into the controller
// bus and streams buffered ADC samples plus acks back to the host.
//
// state  | meaning
// S_IDLE | hunting for the sync byte
// S_CW   | expecting the control word
// S_CH   | expecting conf[15:8]
// S_CL   | expecting conf[7:0]
// S_NH   | expecting {mode, 000, n[11:8]}
// S_NL   | expecting n[7:0]
// S_CK   | expecting the XOR checksum
// T_IDLE | transmitter free, picks ack first, then a sample
// T_ACK  | ack/nack byte on the link
// T_HI   | sample high byte on the link
// T_LO   | sample low byte on the link
module host_cmd_bridge
  import host_cmd_pkg::*;
#(
  parameter int EN_CYCLES = 4,
  parameter int TIMEOUT   = 50000,
  parameter int FIFO_AW   = 4
) (
  input logic              clk,
  input logic              rst,
  host_cmd_bridge_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  parseState_t pState;
  txState_t    tState;

  logic [7:0]    shCw, shCh, shCl, shNh, shNl;
  logic [TW-1:0] idleCnt;
  logic [7:0]    enCnt;
  logic [7:0]    ckCalc;
  logic          ckDone;
  logic          ckOk;

  logic          readyPrev;
  logic          sampleEdge;
  logic          sampleDrop;
  logic          fifoPop;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [11:0]   fifoDout;
  logic [7:0]    sampleLo;
  logic          ackPend;
  logic [7:0]    ackByte;

  assign ckCalc     = shCw ^ shCh ^ shCl ^ shNh ^ shNl;
  assign ckDone     = (pState == S_CK) && bus.rx_valid;
  assign ckOk       = ckDone && (bus.rx_data == ckCalc);
  assign sampleEdge = bus.ready_adc && !readyPrev;
  assign fifoPop    = (tState == T_IDLE) && !ackPend && !fifoEmpty;
  assign sampleDrop = sampleEdge && fifoFull && !fifoPop;

  sample_fifo #(.AW(FIFO_AW)) uFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sampleEdge),
    .pop   (fifoPop),
    .din   (bus.data_adc),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  // Frame parser, inter-byte timeout, output bus update and ctrl_en pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pState        <= S_IDLE;
      shCw          <= '0;
      shCh          <= '0;
      shCl          <= '0;
      shNh          <= '0;
      shNl          <= '0;
      idleCnt       <= '0;
      enCnt         <= '0;
      bus.ctrl_word <= '0;
      bus.conf_word <= '0;
      bus.mode_adc  <= 1'b0;
      bus.n_samples <= '0;
      bus.ctrl_en   <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.frame_err <= 1'b0;

      if (bus.rx_valid) idleCnt <= TW'(TIMEOUT);
      else if (idleCnt != '0) idleCnt <= idleCnt - 1'b1;

      case (pState)
        S_IDLE: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) pState <= S_CW;
        S_CW:   if (bus.rx_valid) begin shCw <= bus.rx_data; pState <= S_CH; end
        S_CH:   if (bus.rx_valid) begin shCh <= bus.rx_data; pState <= S_CL; end
        S_CL:   if (bus.rx_valid) begin shCl <= bus.rx_data; pState <= S_NH; end
        S_NH:   if (bus.rx_valid) begin shNh <= bus.rx_data; pState <= S_NL; end
        S_NL:   if (bus.rx_valid) begin shNl <= bus.rx_data; pState <= S_CK; end
        S_CK: begin
          if (bus.rx_valid) begin
            pState <= S_IDLE;
            if (ckOk) begin
              bus.ctrl_word <= shCw;
              bus.conf_word <= {shCh, shCl};
              bus.mode_adc  <= shNh[7];
              bus.n_samples <= {shNh[3:0], shNl};
            end else begin
              bus.frame_err <= 1'b1;
            end
          end
        end
        default: pState <= S_IDLE;
      endcase

      // A stalled frame is abandoned once the idle counter runs out.
      if (pState != S_IDLE && !bus.rx_valid && idleCnt == TW'(1)) begin
        pState        <= S_IDLE;
        bus.frame_err <= 1'b1;
      end

      // A new command restarts the pulse so ctrl_en never gaps between commands.
      if (ckOk) begin
        bus.ctrl_en <= 1'b1;
        enCnt       <= 8'(EN_CYCLES);
      end else if (bus.ctrl_en) begin
        if (enCnt == 8'd1) bus.ctrl_en <= 1'b0;
        enCnt <= enCnt - 1'b1;
      end
    end
  end

  // Rising-edge detect on ready_adc and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readyPrev    <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      readyPrev <= bus.ready_adc;
      if (ckOk) bus.overflow <= 1'b0;
      if (sampleDrop) bus.overflow <= 1'b1;
    end
  end

  // One-deep ack queue and the byte serializer toward the host.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tState       <= T_IDLE;
      ackPend      <= 1'b0;
      ackByte      <= '0;
      sampleLo     <= '0;
      bus.tx_data  <= '0;
      bus.tx_valid <= 1'b0;
    end else begin
      // A newer ack replaces one still waiting; the one being loaded now is already out.
      if (ckDone) begin
        ackPend <= 1'b1;
        ackByte <= ckOk ? ACK_BYTE : NACK_BYTE;
      end else if (tState == T_IDLE && ackPend) begin
        ackPend <= 1'b0;
      end

      case (tState)
        T_IDLE: begin
          if (ackPend) begin
            bus.tx_data  <= ackByte;
            bus.tx_valid <= 1'b1;
            tState       <= T_ACK;
          end else if (!fifoEmpty) begin
            bus.tx_data  <= {SAMPLE_TAG, fifoDout[11:8]};
            sampleLo     <= fifoDout[7:0];
            bus.tx_valid <= 1'b1;
            tState       <= T_HI;
          end
        end
        T_ACK: begin
          if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            tState       <= T_IDLE;
          end
        end
        T_HI: begin
          if (bus.tx_ready) begin
            bus.tx_data <= sampleLo;
            tState      <= T_LO;
          end
        end
        T_LO: begin
          if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            tState       <= T_IDLE;
          end
        end
        default: tState <= T_IDLE;
      endcase
    end
  end

endmodule
